// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one-deep pending buffer, blanked digit
// changes for a registered shared decoder, and frame-aligned value promotion.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    load_lz,
    output logic                    load_ready,
    output logic [3:0]              dec_value,
    output logic [NUM_DIGITS-1:0]   oAn,
    output logic                    frame_done
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] LAST_CNT   = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0] LAST_SLOT  = SW'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_ctrl: NUM_DIGITS must be in 2..8");
        end
        if (BLANK_CYCLES < 2 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
            $error("seg_scan_ctrl: need 2 <= BLANK_CYCLES < DWELL_CYCLES");
        end
    endgenerate

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [DW-1:0]         act_q, act_d;
    logic                  act_lz_q, act_lz_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q;
    logic [3:0]            dec_q, dec_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  boundary;
    logic                  transfer;

    assign boundary = (state_q == ST_SHOW) && (cnt_q == LAST_CNT) && (slot_q == LAST_SLOT);
    assign transfer = load_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        slot_d      = slot_q;
        act_d       = act_q;
        act_lz_d    = act_lz_q;
        pend_d      = pend_q;
        pend_lz_d   = pend_lz_q;
        pend_full_d = pend_full_q;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            default: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
                end
            end
        endcase

        // Promotion looks at the old full bit, so a same-edge capture waits a frame.
        if (boundary && pend_full_q) begin
            act_d       = pend_q;
            act_lz_d    = pend_lz_q;
            pend_full_d = 1'b0;
        end
        if (transfer) begin
            pend_d      = load_data;
            pend_lz_d   = load_lz;
            pend_full_d = 1'b1;
        end
    end

    // Output registers are loaded from next-state values so they align with the FSM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = act_lz_d && (act_d[DW-1:4*gi] == '0);
            end
            assign an_d[gi] = !((state_d == ST_SHOW) && (slot_d == SW'(gi)) && !suppress[gi]);
        end
    endgenerate

    assign dec_d = act_d[{slot_d, 2'b00} +: 4];
    assign fd_d  = (state_d == ST_SHOW) && (slot_d == LAST_SLOT) && (cnt_d == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            slot_q      <= '0;
            act_q       <= '0;
            act_lz_q    <= 1'b0;
            pend_q      <= '0;
            pend_lz_q   <= 1'b0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            dec_q       <= 4'h0;
            an_q        <= '1;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            act_q       <= act_d;
            act_lz_q    <= act_lz_d;
            pend_q      <= pend_d;
            pend_lz_q   <= pend_lz_d;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
            dec_q       <= dec_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign load_ready = ready_q;
    assign dec_value  = dec_q;
    assign oAn        = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_lz;
    logic        load_ready;
    logic [3:0]  dec_value;
    logic [3:0]  oAn;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cur_frame = 0;
    int cur_cyc   = 0;
    bit model_full = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_lz   (load_lz),
        .load_ready(load_ready),
        .dec_value (dec_value),
        .oAn       (oAn),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s frame=%0d cyc=%0d got=%0h exp=%0h", tag, cur_frame, cur_cyc, got, exp);
        end
    endtask

    // One clock; tracks the pending buffer occupancy the spec requires for load_ready.
    task automatic step(input bit bnd);
        bit xfer;
        xfer = load_valid && !model_full;
        @(posedge clk);
        #1;
        if (xfer) begin
            model_full = 1'b1;
            load_valid = 1'b0;
        end else if (bnd && model_full) begin
            model_full = 1'b0;
        end
    endtask

    // an_p / dec_p hold the hand-computed oAn and digit for slots 3..0 (slot 0 lowest nibble).
    task automatic run_frame(input logic [15:0] an_p, input logic [15:0] dec_p,
                             input int ld_cyc, input logic [15:0] ld_data, input logic ld_lz,
                             input int ld2_cyc, input logic [15:0] ld2_data, input int stop_at);
        int s;
        int k;
        for (int c = 0; c < stop_at; c++) begin
            cur_cyc = c;
            s = c / 8;
            k = c % 8;
            if (c == ld_cyc) begin
                load_valid = 1'b1;
                load_data  = ld_data;
                load_lz    = ld_lz;
            end
            if (c == ld2_cyc) begin
                load_valid = 1'b1;
                load_data  = ld2_data;
                load_lz    = 1'b0;
            end
            chk("oAn", 32'(oAn), (k < 2) ? 32'hF : 32'(an_p[s*4 +: 4]));
            chk("dec_value", 32'(dec_value), 32'(dec_p[s*4 +: 4]));
            chk("frame_done", 32'(frame_done), 32'(c == 31));
            chk("load_ready", 32'(load_ready), 32'(!model_full));
            step(c == 31);
        end
        cur_frame++;
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_lz    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oAn", 32'(oAn), 32'hF);
        chk("rst_dec", 32'(dec_value), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // F0 idle scan, load 3A5F at cycle 5
        run_frame(16'h7BDE, 16'h0000, 5, 16'h3A5F, 1'b0, -1, 16'h0, 32);
        // F1 shows 3A5F; 1234 taken at 2, BEEF offered from 10 and held off
        run_frame(16'h7BDE, 16'h3A5F, 2, 16'h1234, 1'b0, 10, 16'hBEEF, 32);
        // F2 shows 1234 for the whole frame; BEEF is captured at cycle 0
        run_frame(16'h7BDE, 16'h1234, -1, 16'h0, 1'b0, -1, 16'h0, 32);
        // F3 shows BEEF; 0040/lz transferred on the frame_done cycle
        run_frame(16'h7BDE, 16'hBEEF, 31, 16'h0040, 1'b1, -1, 16'h0, 32);
        // F4 still BEEF: the boundary-cycle capture waits one more frame
        run_frame(16'h7BDE, 16'hBEEF, -1, 16'h0, 1'b0, -1, 16'h0, 32);
        // F5 0040 with suppression of digits 3 and 2; load 0000/lz
        run_frame(16'hFFDE, 16'h0040, 3, 16'h0000, 1'b1, -1, 16'h0, 32);
        // F6 0000/lz: only digit 0 lit; load 5678
        run_frame(16'hFFFE, 16'h0000, 1, 16'h5678, 1'b0, -1, 16'h0, 32);
        // F7 shows 5678 with 9ABC pending, interrupted in slot 2 SHOW
        run_frame(16'h7BDE, 16'h5678, 0, 16'h9ABC, 1'b0, -1, 16'h0, 20);
        chk("pre_rst_oAn", 32'(oAn), 32'hB);
        chk("pre_rst_ready", 32'(load_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("async_oAn", 32'(oAn), 32'hF);
        chk("async_ready", 32'(load_ready), 32'h1);
        model_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // F8/F9: restart at slot 0 showing 0; pending 9ABC was discarded
        run_frame(16'h7BDE, 16'h0000, -1, 16'h0, 1'b0, -1, 16'h0, 32);
        run_frame(16'h7BDE, 16'h0000, -1, 16'h0, 1'b0, -1, 16'h0, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
